// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_serializer
//  Purpose  : Pops bytes from an upstream TX FIFO and sends 8N1 UART frames
//             (8E1 when UART_TX_PARITY_EN is defined).
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] fifo_data_in,
    input  logic       fifo_empty,
    output logic       fifo_read_en,
    input  logic       tx_en,
    output logic       tx_out,
    output logic       tx_busy
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] LOAD   = 3'd2;
    localparam logic [2:0] START  = 3'd3;
    localparam logic [2:0] DATA   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd5;
`endif
    localparam logic [2:0] STOP   = 3'd6;

    logic [2:0]        r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_tx;
`ifdef UART_TX_PARITY_EN
    logic              r_parity;
`endif

    logic              w_baud_done;
    logic [BAUD_W-1:0] w_baud_nxt;

    assign w_baud_done = (r_baud == BAUD_LAST);
    assign w_baud_nxt  = w_baud_done ? '0 : r_baud + BAUD_W'(1);

    // tx_out is loaded on state entry, so the line always matches the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_baud <= '0;
                    r_tx   <= 1'b1;
                    if (tx_en && !fifo_empty) begin
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    r_state <= LOAD;
                end
                LOAD: begin
                    r_shift   <= fifo_data_in;
                    r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                    r_parity  <= ^fifo_data_in;
`endif
                    r_tx      <= 1'b0;
                    r_state   <= START;
                end
                START: begin
                    r_baud <= w_baud_nxt;
                    if (w_baud_done) begin
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    r_baud <= w_baud_nxt;
                    if (w_baud_done) begin
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    r_baud <= w_baud_nxt;
                    if (w_baud_done) begin
                        r_tx    <= 1'b1;
                        r_state <= STOP;
                    end
                end
`endif
                STOP: begin
                    r_baud <= w_baud_nxt;
                    r_tx   <= 1'b1;
                    if (w_baud_done) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_baud  <= '0;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign fifo_read_en = (r_state == FETCH);
    assign tx_busy      = (r_state != IDLE);
    assign tx_out       = r_tx;

endmodule
`default_nettype wire
